imm_decode_ctrl: RTL
====================

Name: imm_decode_ctrl

Overview:
- Sequencer in front of the immediate extender (`extensor`) in the multicycle RV64I core.
- Accepts a fetched instruction over a valid/ready handshake and holds it in an instruction register.
- Decodes the opcode into the extender type select, drives `extensor`, and registers the 64-bit immediate it returns.
- Presents the result to the execute FSM over a second valid/ready handshake, flags illegal opcodes, and counts decoded and illegal instructions.

Parameters:
CNT_W, 16, width of the decoded-instruction and illegal-instruction counters (saturating)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
instr_in  input  32  instruction word from fetch
instr_valid  input  1  instr_in valid
instr_ready  output  1  block can accept an instruction
ext_entrada  output  32  to extensor entrada; always equals IR
ext_sel  output  4  to extensor sel: 0=I, 1=S, 2=SB, 3=U
imm_in  input  64  from extensor saida (combinational)
imm_out  output  64  registered immediate
imm_type  output  3  0=none(R), 1=I, 2=S, 3=SB, 4=U
dec_valid  output  1  imm_out/imm_type/illegal valid
dec_ready  input  1  execute FSM consumes the result
illegal  output  1  opcode unsupported; qualified by dec_valid
busy  output  1  state != IDLE
dec_count  output  CNT_W  instructions completed, saturating
ill_count  output  CNT_W  illegal instructions completed, saturating

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, IR=0, imm_out=0, imm_type=0, ext_sel=0, dec_valid=0, illegal=0, both counters=0. instr_ready=1 once reset deasserts.
- States: IDLE, DECODE, CAPTURE, HOLD.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready: IR<=instr_in, go to DECODE.
  - No accept without instr_valid.
- DECODE:
  - instr_ready=0.
  - ext_sel is registered from IR[6:0], so it is stable for the whole CAPTURE cycle.
  - Opcode decode:
    - 0000011, 0010011, 1100111 → sel 0, type I.
    - 0100011 → sel 1, type S.
    - 1100011 → sel 2, type SB.
    - 0110111, 0010111 → sel 3, type U.
    - 0110011, 0111011 → sel 0, type none.
    - Any other opcode, including JAL 1101111, 0011011 and 0000000 → sel 0, type none, illegal flag set.
  - Go to CAPTURE.
- CAPTURE:
  - imm_out<=imm_in for types I/S/SB/U.
  - imm_out<=0 for type none or illegal.
  - Set dec_valid=1, go to HOLD.
- HOLD:
  - imm_out, imm_type, illegal and ext_sel are stable while dec_valid=1 and !dec_ready.
  - On dec_ready: dec_valid<=0, dec_count+=1 (saturates at all-ones), ill_count+=1 if illegal (saturates), go to IDLE.
- Latency: accept at edge N; dec_valid high after edge N+2; earliest next accept at edge N+4 (IDLE at N+3).
- dec_ready is ignored outside HOLD.
- instr_valid is ignored outside IDLE; the fetch stage must hold instr_in until accepted.
- ext_entrada equals IR in all states.
- Width rule: imm_out is exactly the extender output. No re-extension is done here; the SB shift-left-by-1 and U <<12 are produced by the extender.
- Reset mid-operation (any state): return to IDLE and reset values on the same assertion; the in-flight instruction is dropped and the counters clear.
- busy = (state != IDLE).

Test Plan:
- Reset then addi x1,x0,-1 (0xFFF00093), dec_ready=1:
  - ext_sel=0 in CAPTURE.
  - imm_out=0xFFFFFFFFFFFFFFFF, imm_type=1, illegal=0.
  - dec_valid 2 cycles after accept; dec_count=1.
- sd with imm=+8 (0x00813423) → ext_sel=1, imm_out=0x8, type=2. Then beq with imm=-4 (0xFE000EE3) → ext_sel=2, type=3, imm_out equals the extender's output for that word.
- lui x5,0x12345 (0x123452B7) → ext_sel=3, type=4, imm_out=0x0000000012345000. Then add (0x002081B3) → type=0, imm_out=0, illegal=0.
- JAL (0x0000006F) then word 0x00000000 → illegal=1 both times, imm_out=0, ill_count=2, dec_count=2.
- Backpressure: dec_ready=0 for 5 cycles in HOLD while instr_valid=1 with a new word → outputs stable, instr_ready=0, new word not accepted; accepted in the cycle after the return to IDLE.
- Assert reset during HOLD with counters at 3 → dec_valid=0, state IDLE, counters=0 immediately. Separately, preset counters to all-ones and decode one instruction → both counters stay saturated.

Source files
------------

// File: rtl/imm_decode_ctrl_if.sv
// Handshake and data bundle between fetch, the immediate decode sequencer,
// the extender and the execute FSM.
interface imm_decode_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      instr_in;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      ext_entrada;
    logic [3:0]       ext_sel;
    logic [63:0]      imm_in;
    logic [63:0]      imm_out;
    logic [2:0]       imm_type;
    logic             dec_valid;
    logic             dec_ready;
    logic             illegal;
    logic             busy;
    logic [CNT_W-1:0] dec_count;
    logic [CNT_W-1:0] ill_count;

    // Sequencer side
    modport slave (
        input  instr_in, instr_valid, imm_in, dec_ready,
        output instr_ready, ext_entrada, ext_sel, imm_out, imm_type,
               dec_valid, illegal, busy, dec_count, ill_count
    );

    // Fetch / extender / execute side
    modport master (
        output instr_in, instr_valid, imm_in, dec_ready,
        input  instr_ready, ext_entrada, ext_sel, imm_out, imm_type,
               dec_valid, illegal, busy, dec_count, ill_count
    );
endinterface

// File: rtl/imm_decode_ctrl.sv
// Immediate decode sequencer: latches an instruction, selects the extender
// format from its opcode, registers the extended immediate and hands it on.
module imm_decode_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input logic            clk,
    input logic            reset,
    imm_decode_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DECODE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_SB   = 3'd3,
        IMM_U    = 3'd4
    } imm_type_e;

    typedef enum logic [3:0] {
        SEL_I  = 4'd0,
        SEL_S  = 4'd1,
        SEL_SB = 4'd2,
        SEL_U  = 4'd3
    } ext_sel_e;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_OPIMM  = 7'b0010011,
        OP_JALR   = 7'b1100111,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_OP     = 7'b0110011,
        OP_OP32   = 7'b0111011
    } opcode_e;

    state_e           state_q;
    logic [31:0]      ir_q;
    ext_sel_e         sel_q;
    ext_sel_e         sel_d;
    imm_type_e        type_q;
    imm_type_e        type_d;
    logic             ill_q;
    logic             ill_d;
    logic [63:0]      imm_q;
    logic             valid_q;
    logic [CNT_W-1:0] dec_cnt_q;
    logic [CNT_W-1:0] ill_cnt_q;

    // Opcode classification; anything not listed (JAL included) is illegal.
    always_comb begin
        sel_d  = SEL_I;
        type_d = IMM_NONE;
        ill_d  = 1'b0;
        case (ir_q[6:0])
            OP_LOAD, OP_OPIMM, OP_JALR: type_d = IMM_I;
            OP_STORE: begin
                sel_d  = SEL_S;
                type_d = IMM_S;
            end
            OP_BRANCH: begin
                sel_d  = SEL_SB;
                type_d = IMM_SB;
            end
            OP_LUI, OP_AUIPC: begin
                sel_d  = SEL_U;
                type_d = IMM_U;
            end
            OP_OP, OP_OP32: begin
                sel_d  = SEL_I;
                type_d = IMM_NONE;
            end
            default: ill_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            sel_q     <= SEL_I;
            type_q    <= IMM_NONE;
            ill_q     <= 1'b0;
            imm_q     <= '0;
            valid_q   <= 1'b0;
            dec_cnt_q <= '0;
            ill_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.instr_valid) begin
                        ir_q    <= bus.instr_in;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    sel_q   <= sel_d;
                    type_q  <= type_d;
                    ill_q   <= ill_d;
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    // Illegal opcodes always decode to IMM_NONE, so one test covers both.
                    imm_q   <= (type_q == IMM_NONE) ? '0 : bus.imm_in;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (bus.dec_ready) begin
                        valid_q <= 1'b0;
                        if (dec_cnt_q != '1) dec_cnt_q <= dec_cnt_q + CNT_W'(1);
                        if (ill_q && (ill_cnt_q != '1)) ill_cnt_q <= ill_cnt_q + CNT_W'(1);
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.ext_entrada = ir_q;
    assign bus.ext_sel     = sel_q;
    assign bus.imm_out     = imm_q;
    assign bus.imm_type    = type_q;
    assign bus.dec_valid   = valid_q;
    assign bus.illegal     = ill_q;
    assign bus.dec_count   = dec_cnt_q;
    assign bus.ill_count   = ill_cnt_q;

endmodule
